// File: rtl/mmind_pkg.sv
// -----------------------------------------------------------------------------
// mmind_pkg
// Shared definitions for the Mastermind game sequencer.
//   state_t     : sequencer states
//   NBITS       : bits compared per guess (a full match is correct == NBITS)
//   NBITS_W     : width of the correct-count input
//   SWCNT_LAST  : last switch-select index scanned before judging
// -----------------------------------------------------------------------------
package mmind_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ARMED,
      ST_CLR,
      ST_SCAN,
      ST_JUDGE,
      ST_WIN,
      ST_LOSE
   } state_t;

   localparam int         NBITS      = 8;
   localparam int         NBITS_W    = 4;
   localparam logic [2:0] SWCNT_LAST = 3'd7;

endpackage

// File: rtl/btn_edge.sv
// -----------------------------------------------------------------------------
// btn_edge
// Conditions a raw push button: two-flop synchronizer, rising-edge detect and
// an output register. A press yields one registered pulse on the 3rd rising
// clk edge after raw rises; holding the button produces no further pulses.
// Ports:
//   clk   : system clock
//   reset : asynchronous, active-high clear
//   raw   : button level, asynchronous to clk
//   pulse : one-cycle registered press pulse
// -----------------------------------------------------------------------------
module btn_edge (
   input  logic clk,
   input  logic reset,
   input  logic raw,
   output logic pulse
);

   logic sync1;
   logic sync2;
   logic sync_q;

   // NOTE: non-blocking assignments make every flop sample the pre-edge value
   // of its neighbour, so the chain shifts by exactly one stage per clock.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1  <= 1'b0;
         sync2  <= 1'b0;
         sync_q <= 1'b0;
         pulse  <= 1'b0;
      end else begin
         sync1  <= raw;
         sync2  <= sync1;
         sync_q <= sync2;
         pulse  <= sync2 & ~sync_q;
      end
   end

endmodule

// File: rtl/mmind_game_ctrl.sv
// -----------------------------------------------------------------------------
// mmind_game_ctrl
// Game-level sequencer for the Mastermind datapath. Loads the answer, runs the
// 8-cycle bit-serial compare, judges each guess and limits the player to
// MAX_TRIES attempts.
// Ports:
//   clk, reset          : clock, asynchronous active-high reset
//   setans, guess       : raw buttons (asynchronous to clk)
//   swcnt               : switch-select counter value from the datapath
//   correct             : correct-bit count from the datapath
//   swcnt_clr, swcnt_en : switch-select counter clear / advance
//   corr_clr, corr_en   : correct counter clear / compare qualify
//   ans_en              : load switches into the answer register
//   tries               : guesses judged since the last answer load
//   win, lose, busy     : status levels for the display
// -----------------------------------------------------------------------------
module mmind_game_ctrl
   import mmind_pkg::*;
#(
   parameter int MAX_TRIES = 8,
   parameter int TRY_W     = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             setans,
   input  logic             guess,
   input  logic [2:0]       swcnt,
   input  logic [3:0]       correct,
   output logic             swcnt_clr,
   output logic             swcnt_en,
   output logic             corr_clr,
   output logic             corr_en,
   output logic             ans_en,
   output logic [TRY_W-1:0] tries,
   output logic             win,
   output logic             lose,
   output logic             busy
);

   localparam logic [TRY_W-1:0]   MAX_T    = TRY_W'(MAX_TRIES);
   localparam logic [TRY_W-1:0]   ONE_T    = TRY_W'(1);
   localparam logic [NBITS_W-1:0] ALL_HITS = NBITS_W'(NBITS);

   state_t           state;
   state_t           state_next;
   logic [TRY_W-1:0] tries_next;
   logic [TRY_W-1:0] tries_inc;
   logic             set_p;
   logic             guess_p;

   btn_edge u_set_edge (
      .clk   (clk),
      .reset (reset),
      .raw   (setans),
      .pulse (set_p)
   );

   btn_edge u_guess_edge (
      .clk   (clk),
      .reset (reset),
      .raw   (guess),
      .pulse (guess_p)
   );

   assign tries_inc = tries + ONE_T;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= ST_IDLE;
         tries <= '0;
      end else begin
         state <= state_next;
         tries <= tries_next;
      end
   end

   // NOTE: every output of this block is given a default before the case so
   // no path leaves a value unassigned, which would infer a latch.
   always_comb begin
      state_next = state;
      tries_next = tries;
      swcnt_clr  = 1'b0;
      swcnt_en   = 1'b0;
      corr_clr   = 1'b0;
      corr_en    = 1'b0;
      ans_en     = 1'b0;
      win        = 1'b0;
      lose       = 1'b0;
      busy       = 1'b0;

      case (state)
         ST_IDLE: begin
            if (set_p) begin
               ans_en     = 1'b1;
               tries_next = '0;
               state_next = ST_ARMED;
            end
         end
         ST_ARMED: begin
            // A simultaneous guess is dropped in favour of the answer reload.
            if (set_p) begin
               ans_en     = 1'b1;
               tries_next = '0;
            end else if (guess_p) begin
               state_next = ST_CLR;
            end
         end
         ST_CLR: begin
            swcnt_clr  = 1'b1;
            corr_clr   = 1'b1;
            busy       = 1'b1;
            state_next = ST_SCAN;
         end
         ST_SCAN: begin
            swcnt_en = 1'b1;
            corr_en  = 1'b1;
            busy     = 1'b1;
            if (swcnt == SWCNT_LAST) state_next = ST_JUDGE;
         end
         ST_JUDGE: begin
            swcnt_clr = 1'b1;
            busy      = 1'b1;
            if (tries != MAX_T) tries_next = tries_inc;
            if (correct == ALL_HITS)   state_next = ST_WIN;
            else if (tries_inc == MAX_T) state_next = ST_LOSE;
            else                       state_next = ST_ARMED;
         end
         ST_WIN, ST_LOSE: begin
            win  = (state == ST_WIN);
            lose = (state == ST_LOSE);
            if (set_p) begin
               ans_en     = 1'b1;
               tries_next = '0;
               state_next = ST_ARMED;
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

endmodule
